// File: rtl/mem_arbiter.sv
// Round-robin N-processor memory arbiter: sole owner of the shared memory request, address and data.
// Optional BUSY watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int NUM_PROC       = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PROC-1:0]           proc_req,
  input  logic [NUM_PROC-1:0]           proc_we,
  input  logic [NUM_PROC*ADDR_W-1:0]    proc_addr,
  input  logic [NUM_PROC*DATA_W-1:0]    proc_wdata,
  output logic [NUM_PROC-1:0]           proc_resp,
  output logic [NUM_PROC-1:0]           proc_error,
  output logic [DATA_W-1:0]             proc_rdata,
  output logic [$clog2(NUM_PROC)-1:0]   grant_id,
  output logic                          busy,
  output logic                          mem_read_req,
  output logic                          mem_write_req,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_write_data,
  input  logic [DATA_W-1:0]             mem_read_data,
  input  logic                          mem_done
);

  localparam int GID_W = $clog2(NUM_PROC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [GID_W-1:0]    last_grant, last_grant_d;
  logic [GID_W-1:0]    grant_id_d;
  logic [GID_W-1:0]    winner;
  logic [NUM_PROC-1:0] resp_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                rd_req_d;
  logic                wr_req_d;
  logic                timeout;

  // First requester found scanning upward from the slot after the previous grantee.
  function automatic logic [GID_W-1:0] rr_pick(input logic [NUM_PROC-1:0] req,
                                                input logic [GID_W-1:0]    last);
    logic [GID_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_PROC; off++) begin
      idx = (int'(last) + off) % NUM_PROC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GID_W'(idx);
      end
    end
    return pick;
  endfunction

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt, busy_cnt_d;

  // Counter is held at zero outside BUSY, so it always starts from zero on entry.
  always_comb begin
    busy_cnt_d = '0;
    timeout    = 1'b0;
    if (state == BUSY) begin
      busy_cnt_d = busy_cnt + CNT_W'(1);
      timeout    = (busy_cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_cnt   <= '0;
      proc_error <= '0;
    end else begin
      busy_cnt   <= busy_cnt_d;
      proc_error <= '0;
      // mem_done on the same edge as the watchdog completes normally.
      if (state == BUSY && timeout && !mem_done)
        proc_error[grant_id] <= 1'b1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign proc_error = '0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_id_d   = grant_id;
    addr_d       = mem_addr;
    wdata_d      = mem_write_data;
    rd_req_d     = mem_read_req;
    wr_req_d     = mem_write_req;
    rdata_d      = proc_rdata;
    resp_d       = '0;
    winner       = rr_pick(proc_req, last_grant);

    unique case (state)
      IDLE: begin
        if (|proc_req) begin
          state_d      = BUSY;
          last_grant_d = winner;
          grant_id_d   = winner;
          addr_d       = proc_addr[int'(winner)*ADDR_W +: ADDR_W];
          wdata_d      = proc_wdata[int'(winner)*DATA_W +: DATA_W];
          rd_req_d     = ~proc_we[winner];
          wr_req_d     = proc_we[winner];
        end
      end
      BUSY: begin
        if (mem_done || timeout) begin
          state_d          = RESP;
          rd_req_d         = 1'b0;
          wr_req_d         = 1'b0;
          resp_d[grant_id] = 1'b1;
          rdata_d          = (mem_done && mem_read_req) ? mem_read_data : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the reset is synchronous and clears every register, including the address/data holding regs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= GID_W'(NUM_PROC - 1);
      grant_id       <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      proc_rdata     <= '0;
      proc_resp      <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      last_grant     <= last_grant_d;
      grant_id       <= grant_id_d;
      mem_addr       <= addr_d;
      mem_write_data <= wdata_d;
      mem_read_req   <= rd_req_d;
      mem_write_req  <= wr_req_d;
      proc_rdata     <= rdata_d;
      proc_resp      <= resp_d;
      busy           <= (state_d != IDLE);
    end
  end

endmodule
